// File: rtl/wfg_mem_arbiter_if.sv
// Requester-side bus of the waveform SRAM read arbiter.
// The arbiter uses the slave modport; the requesters use the master modport.
interface wfg_mem_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 10,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_i;
    logic [NREQ-1:0]    lock_i;
    logic [NREQ*AW-1:0] addr_i;
    logic [NREQ-1:0]    gnt_o;
    logic [NREQ-1:0]    rvalid_o;
    logic [DW-1:0]      rdata_o;

    modport master (
        output req_i, lock_i, addr_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, lock_i, addr_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/wfg_mem_arbiter.sv
// Round-robin read arbiter for the single read port of the waveform SRAM.
// The grant is combinational in the request cycle and drives the SRAM pins
// directly. A requester may hold the grant for up to MAX_BURST consecutive
// cycles using lock_i. The one-hot grant travels down a LATENCY-deep pipeline
// so that the returning data is tagged with its owner.
module wfg_mem_arbiter #(
    parameter int NREQ      = 2,
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int LATENCY   = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    wfg_mem_arbiter_if.slave    bus,
    output logic                csb1,
    output logic [AW-1:0]       addr1,
    input  logic [DW-1:0]       dout1
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);
    localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);

    logic                active_r;
    logic [IW-1:0]       last_r;
    logic [BW-1:0]       burst_r;
    logic                lock_r;
    logic [NREQ-1:0]     pipe_r [LATENCY];

    logic [NREQ-1:0]     gnt_s;
    logic [IW-1:0]       win_s;
    logic [IW-1:0]       idx_s;
    logic                found_s;
    logic                hold_s;
    logic [AW-1:0]       addr_s;

    // Hold off arbitration until the first clock edge after reset release.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            active_r <= 1'b0;
        end else begin
            active_r <= 1'b1;
        end
    end

    // Pick the winner: locked owner first, otherwise round-robin after last_r.
    always_comb begin
        gnt_s   = '0;
        win_s   = last_r;
        idx_s   = last_r;
        found_s = 1'b0;
        // lock_r is only ever set when last_r was granted in the previous cycle.
        hold_s  = lock_r && bus.req_i[last_r] && (burst_r < BURST_MAX);
        if (!active_r) begin
            found_s = 1'b0;
        end else if (hold_s) begin
            found_s = 1'b1;
            win_s   = last_r;
        end else begin
            for (int i = 1; i <= NREQ; i++) begin
                if (int'(last_r) + i >= NREQ) begin
                    idx_s = IW'(int'(last_r) + i - NREQ);
                end else begin
                    idx_s = IW'(int'(last_r) + i);
                end
                if (!found_s && bus.req_i[idx_s]) begin
                    found_s = 1'b1;
                    win_s   = idx_s;
                end else begin
                    found_s = found_s;
                end
            end
        end
        if (found_s) begin
            gnt_s[win_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    // Route the granted requester's address to the SRAM; zero when idle.
    always_comb begin
        addr_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_s[k]) begin
                addr_s = bus.addr_i[k*AW +: AW];
            end else begin
                addr_s = addr_s;
            end
        end
    end

    // Track last winner, burst length and whether the winner asked to lock.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            last_r  <= LAST_RST;
            burst_r <= '0;
            lock_r  <= 1'b0;
        end else if (!found_s) begin
            burst_r <= '0;
            lock_r  <= 1'b0;
        end else begin
            last_r <= win_s;
            lock_r <= bus.lock_i[win_s];
            // A non-zero burst count means last_r was granted last cycle.
            if ((burst_r != '0) && (win_s == last_r) && (burst_r < BURST_MAX)) begin
                burst_r <= burst_r + BURST_ONE;
            end else begin
                burst_r <= BURST_ONE;
            end
        end
    end

    // Carry the one-hot grant alongside the SRAM read latency.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int s = 0; s < LATENCY; s++) begin
                pipe_r[s] <= '0;
            end
        end else begin
            pipe_r[0] <= gnt_s;
            for (int s = 1; s < LATENCY; s++) begin
                pipe_r[s] <= pipe_r[s-1];
            end
        end
    end

    assign bus.gnt_o    = gnt_s;
    assign bus.rvalid_o = pipe_r[LATENCY-1];
    assign bus.rdata_o  = dout1;
    assign csb1         = ~(|gnt_s);
    assign addr1        = addr_s;
endmodule

// File: doc/wfg_mem_arbiter.md
Name: wfg_mem_arbiter

Overview:
- Arbitrates the single read port of the waveform SRAM (csb1/addr1/dout1) between NREQ read requesters, e.g. the memory stimulus and a second memory-backed stimulus or debug readback.
- Grants one read per cycle using round-robin with an optional bounded burst lock.
- Tracks the SRAM read latency and returns data to the owner of each read with a per-requester valid strobe.
- Sits between the stimulus blocks and the SRAM macro pins in the top level.

Parameters:
NREQ, 2, number of requesters (2..8)
AW, 10, SRAM address width
DW, 32, SRAM data width
LATENCY, 1, cycles from accepted request (csb1 low at clock edge) to valid dout1 (1..4)
MAX_BURST, 16, max consecutive locked grants to one requester while others wait (>=1)

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  reset, asynchronous, active-low
req_i  in  NREQ  read request per requester
lock_i  in  NREQ  requester asks to keep the grant on its next cycle
addr_i  in  NREQ*AW  read address; requester k uses bits [k*AW +: AW]
gnt_o  out  NREQ  one-hot grant; read accepted when req_i[k] & gnt_o[k]
rvalid_o  out  NREQ  one-hot read-data valid for requester k
rdata_o  out  DW  read data, meaningful only while any rvalid_o bit is set
csb1  out  1  SRAM chip select, active-low
addr1  out  AW  SRAM read address
dout1  in  DW  SRAM read data

Behaviour:
- Reset (wb_rst_ni low, asynchronous): gnt_o=0, csb1=1, addr1=0, rvalid_o=0, latency pipeline cleared, rr pointer=NREQ-1 (requester 0 highest priority first), burst counter=0, lock owner cleared.
- Outputs stay in reset values while reset is held. Deassertion is synchronised internally; the first grant can occur in the first cycle after deassertion.
- Grant is combinational from req_i and registered state, in the same cycle as the request. At most one gnt_o bit is set, and only for a requester with req_i high. No request gives gnt_o=0.
- Round-robin: search starts at (last granted + 1) mod NREQ and wraps. The winner becomes the new last granted.
- Lock: a held grant goes to requester k even if others request, when all of these hold:
  - k was granted in the previous cycle;
  - lock_i[k] was high in that cycle;
  - req_i[k] is high now;
  - burst count < MAX_BURST.
- Burst count: increments on each consecutive grant to the same requester. It resets to 1 on a grant to a different requester and to 0 on an idle cycle.
- At MAX_BURST, the lock is ignored for one arbitration and normal round-robin applies. If no other requester is pending, k is granted again and the count restarts at 1.
- If the lock owner drops req_i, the lock ends immediately and round-robin applies that cycle.
- SRAM drive: csb1 = ~(|gnt_o); addr1 = the granted requester's address; addr1=0 when idle. The SRAM samples both at the rising edge ending the grant cycle.
- Return path: a LATENCY-deep shift register carries the one-hot grant vector. rvalid_o equals the stage-LATENCY output. rdata_o = dout1 passed through combinationally; no extra register.
- A grant in cycle t gives rvalid_o[k] high in cycle t+LATENCY for exactly one cycle.
- Throughput: one read per cycle sustained; reads return in grant order; no backpressure on the return path.
- Requesters must consume rdata_o in the rvalid cycle.
- Reset mid-operation: in-flight reads are discarded, rvalid_o is not asserted for them, and the SRAM is deselected immediately.
- Width rule: burst counter is $clog2(MAX_BURST+1) bits and saturates at MAX_BURST.
- Out-of-range addresses are not checked; addr_i passes through unmodified.

Test Plan:
- Requester 0 only, addr 0x005 then 0x006 on back-to-back cycles, LATENCY=1 -> gnt_o=01 both cycles. csb1 low two cycles with addr1=0x005, 0x006. rvalid_o[0] high the following two cycles carrying SRAM words 5, 6.
- Both requesters continuously requesting, no lock, from reset -> grants alternate 01,10,01,10… Requester 0 wins first. rvalid_o follows one cycle later with matching one-hot ID.
- Requester 1 requesting with lock_i[1]=1, requester 0 requesting continuously, MAX_BURST=4 -> requester 1 granted exactly 4 consecutive cycles, then requester 0 granted 1 cycle, then requester 1 resumes.
- Requester 1 locked, drops req_i mid-burst -> requester 0 granted in that same cycle. Burst count restarts at 1.
- Grant to requester 0 in cycle t, wb_rst_ni pulsed low asynchronously mid-cycle before t+1 -> gnt_o=0 and csb1=1 immediately. No rvalid_o in t+1. After release, arbitration restarts with requester 0 first.
- LATENCY=3, 8 alternating reads to addresses 0..7 -> each rvalid_o exactly 3 cycles after its grant, in order, with the correct ID and data. csb1 low for 8 consecutive cycles.
